// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the execute stage.
//
// Runs one MULTU/MULT/DIVU/DIV at a time. A normal operation iterates for
// WIDTH cycles and a divide by zero takes one cycle. Both finish with a
// one-cycle ready_o pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start_i    request a new operation (sampled only in IDLE)
//   op_i       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opdata1_i  multiplicand / dividend
//   opdata2_i  multiplier / divisor
//   annul_i    cancel the operation in flight (RUN / DIVZERO)
//   result_o   {HI, LO}: full product, or {remainder, quotient}
//   ready_o    one-cycle completion pulse, result_o valid while high
//   busy_o     operation in flight (stall request), low in DONE
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;    // product sign for multiply, quotient sign for divide
  logic               neg_r;    // remainder sign
  logic [WIDTH-1:0]   mag_b;    // multiplicand magnitude (mul) / divisor magnitude (div)
  logic [2*WIDTH-1:0] acc, acc_n;
  logic               accept, div_by_zero;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum, shifted, diff;

  // Two's-complement magnitude. The most-negative value maps to 2^(WIDTH-1),
  // which fits because the magnitude is treated as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // Apply the recorded signs to the unsigned iteration result.
  function automatic logic [2*WIDTH-1:0] sign_correct(input logic [2*WIDTH-1:0] raw,
                                                      input logic               div,
                                                      input logic               nq,
                                                      input logic               nr);
    logic [WIDTH-1:0] hi, lo;
    hi = raw[2*WIDTH-1:WIDTH];
    lo = raw[WIDTH-1:0];
    if (!div) return nq ? -raw : raw;
    return {(nr ? -hi : hi), (nq ? -lo : lo)};
  endfunction

  assign accept      = (state == IDLE) && start_i && !annul_i;
  assign div_by_zero = op_i[1] && (opdata2_i == '0);

  // One iteration step. For multiply, acc = {partial product, remaining
  // multiplier bits}, consumed LSB first. For divide, acc = {partial remainder,
  // dividend bits shifting out MSB first / quotient bits shifting in at LSB}.
  always_comb begin
    addend  = acc[0] ? mag_b : '0;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, mag_b};
    acc_n   = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // The remainder stays below the divisor, so a negative difference keeps
      // the shifted value, which then fits in WIDTH bits.
      if (diff[WIDTH]) acc_n = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_n = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = div_by_zero ? DIVZERO : RUN;
      DIVZERO: state_n = annul_i ? IDLE : DONE;
      RUN: begin
        if (annul_i)          state_n = IDLE;
        else if (cnt == LAST) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      // Outputs are registered from the next state so they line up with it.
      ready_o <= (state_n == DONE);
      busy_o  <= (state_n == RUN) || (state_n == DIVZERO);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            is_div <= op_i[1];
            neg_q  <= op_i[0] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r  <= op_i[0] & opdata1_i[WIDTH-1];
            if (op_i[1]) begin
              mag_b <= magnitude(opdata2_i, op_i[0]);
              acc   <= {{WIDTH{1'b0}}, magnitude(opdata1_i, op_i[0])};
            end else begin
              mag_b <= magnitude(opdata1_i, op_i[0]);
              acc   <= {{WIDTH{1'b0}}, magnitude(opdata2_i, op_i[0])};
            end
          end
        end
        RUN: begin
          if (!annul_i) begin
            acc <= acc_n;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) result_o <= sign_correct(acc_n, is_div, neg_q, neg_r);
          end
        end
        DIVZERO: begin
          if (!annul_i) result_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (WIDTH=32). Stimulus pushes the expected
// result when it issues a start; a monitor pops on every ready_o pulse.
module tb_ex_muldiv;
  localparam int W = 32;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;
  localparam int LAT  = W + 1;  // edges counted from the accept edge (inclusive) to ready
  localparam int LATZ = 2;

  logic           clk = 1'b0;
  logic           rst, start_i, annul_i;
  logic [1:0]     op_i;
  logic [W-1:0]   opdata1_i, opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o, busy_o;

  int n_cmp = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  int accepted = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp = '0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got result %h, expected no ready pulse", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
  end

  // Issue one operation, then follow it to completion checking latency and busy.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat);
    int edges, busy_cycles;
    @(negedge clk);
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    exp_q.push_back(exp);
    accepted++;
    last_exp = exp;
    @(posedge clk); #1;
    start_i = 1'b0;
    edges = 1;
    busy_cycles = 0;
    while (!ready_o && edges < 200) begin
      if (busy_o) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, edges, lat);
    check({name, "_busy_cycles"}, busy_cycles, lat - 1);
    check({name, "_busy_in_done"}, busy_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_before;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, '0);
    check("reset_ready", ready_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    @(negedge clk) rst = 1'b0;

    run_op("multu_ones", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, LAT);
    run_op("mult_neg3x5", MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, LAT);
    run_op("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, LAT);
    run_op("mult_7xneg1", MULT, 32'd7, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, LAT);
    run_op("div_neg7by2", DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT);
    run_op("div_100byneg7", DIV, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, LAT);
    run_op("div_minnegbyneg1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, LAT);
    run_op("divu_100by7", DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT);
    run_op("divu_maxby16", DIVU, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, LAT);
    run_op("divu_by0", DIVU, 32'd100, 32'd0, 64'd0, LATZ);
    run_op("b2b_after_div0", DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT);
    run_op("div_by0_signed", DIV, 32'hFFFF_FFFB, 32'd0, 64'd0, LATZ);
    run_op("multu_small", MULTU, 32'd6, 32'd7, 64'd42, LAT);

    // Annul on the 10th RUN cycle: no completion, result untouched.
    ready_before = ready_cnt;
    @(negedge clk);
    op_i = MULTU; opdata1_i = 32'h1234_5678; opdata2_i = 32'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_busy", busy_o, 1'b0);
    check("annul_result_held", result_o, last_exp);
    repeat (40) @(posedge clk);
    #1;
    check("annul_no_ready", ready_cnt, ready_before);
    run_op("divu_9by3_after_annul", DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, LAT);

    // Asynchronous reset between edges in the middle of RUN.
    ready_before = ready_cnt;
    @(negedge clk);
    op_i = MULTU; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_ready", ready_o, 1'b0);
    check("async_rst_result", result_o, '0);
    @(negedge clk) rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_ready", ready_cnt, ready_before);
    check("rst_idle_busy", busy_o, 1'b0);
    run_op("mult_after_rst", MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, LAT);

    // start_i held high throughout: the second operands only land in IDLE.
    ready_before = ready_cnt;
    @(negedge clk);
    op_i = MULT; opdata1_i = 32'hFFFF_FFFD; opdata2_i = 32'd5; start_i = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    exp_q.push_back({32'd2, 32'd14});
    accepted += 2;
    @(posedge clk); #1;
    op_i = DIVU; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int i = 0; i < 200 && !ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("held_start_first_ready", ready_o, 1'b1);
    @(posedge clk);   // DONE -> IDLE, start ignored in DONE
    @(posedge clk);   // accepted in IDLE
    #1 start_i = 1'b0;
    for (int i = 0; i < 200 && !ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("held_start_second_ready", ready_o, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("held_start_ready_count", ready_cnt - ready_before, 2);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_ready_count", ready_cnt, accepted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
